// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Builds fixed-format command frames from the UART receive byte stream:
//   SYNC, OPCODE, ADDR, D3, D2, D1, D0 [, CHK]
// and holds each completed command on a valid/ready handshake.
// Malformed, stalled or overrunning frames are dropped. Each such frame
// produces a one-cycle error pulse.
//
// Build option:
//   RX_CHECKSUM_EN defined   -> 8-byte frame. The trailing CHK byte must equal
//                               the XOR of OPCODE..D0.
//   RX_CHECKSUM_EN undefined -> 7-byte frame with no checksum. err_chk is tied to 0.
//
// State table:
//   HUNT     | idle, waiting for SYNC_BYTE; any other byte is ignored
//   GET_OP   | expecting the opcode byte
//   GET_ADDR | expecting the address byte
//   GET_DATA | shifting in four data bytes, MSB first (r_idx counts them)
//   GET_CHK  | expecting the checksum byte (checksum build only)
//   HOLD     | command presented on o_cmd_*, frozen until accepted

module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_cmd_opcode,
    output logic [7:0]  o_cmd_addr,
    output logic [31:0] o_cmd_data,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_busy,
    output logic        o_err_chk,
    output logic        o_err_timeout,
    output logic        o_err_overrun
);

    // The expiry decision is made one clock before the counter would reach
    // TIMEOUT_CYCLES. This puts the registered pulse exactly TIMEOUT_CYCLES
    // clocks after the last strobe.
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        GET_OP   = 3'd1,
        GET_ADDR = 3'd2,
        GET_DATA = 3'd3,
        GET_CHK  = 3'd4,
        HOLD     = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [19:0] r_tmo_cnt;
    logic [7:0]  r_cmd_opcode;
    logic [7:0]  r_cmd_addr;
    logic [31:0] r_cmd_data;
    logic        r_cmd_valid;
    logic        r_busy;
    logic        r_err_timeout;
    logic        r_err_overrun;
`ifdef RX_CHECKSUM_EN
    logic [7:0]  r_xor;
    logic        r_err_chk;
`endif

    logic w_in_frame;
    logic w_tmo_expire;
    logic w_sync_seen;

    assign w_in_frame   = (r_state != HUNT) && (r_state != HOLD);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_tmo_expire = w_in_frame && !i_rx_valid && (r_tmo_cnt == TMO_LAST);
    assign w_sync_seen  = i_rx_valid && (i_rx_data == SYNC_BYTE);

    // Inter-byte idle counter: runs only while a frame is partially collected.
    always_ff @(posedge clk) begin
        if (rst || i_rx_valid || !w_in_frame) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 20'd1;
        end
    end

    // Frame FSM. It also drives every registered output, so the command, busy
    // and error pulses all change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_idx         <= '0;
            r_cmd_opcode  <= '0;
            r_cmd_addr    <= '0;
            r_cmd_data    <= '0;
            r_cmd_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
`ifdef RX_CHECKSUM_EN
            r_xor         <= '0;
            r_err_chk     <= 1'b0;
`endif
        end else begin
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
`ifdef RX_CHECKSUM_EN
            r_err_chk     <= 1'b0;
`endif
            if (w_tmo_expire) begin
                r_state       <= HUNT;
                r_busy        <= 1'b0;
                r_idx         <= '0;
                r_err_timeout <= 1'b1;
`ifdef RX_CHECKSUM_EN
                r_xor         <= '0;
`endif
            end else begin
                case (r_state)
                    HUNT: begin
                        if (w_sync_seen) begin
                            r_state <= GET_OP;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
`ifdef RX_CHECKSUM_EN
                            r_xor   <= '0;
`endif
                        end
                    end

                    GET_OP: begin
                        if (i_rx_valid) begin
                            r_cmd_opcode <= i_rx_data;
                            r_state      <= GET_ADDR;
`ifdef RX_CHECKSUM_EN
                            r_xor        <= r_xor ^ i_rx_data;
`endif
                        end
                    end

                    GET_ADDR: begin
                        if (i_rx_valid) begin
                            r_cmd_addr <= i_rx_data;
                            r_state    <= GET_DATA;
`ifdef RX_CHECKSUM_EN
                            r_xor      <= r_xor ^ i_rx_data;
`endif
                        end
                    end

                    GET_DATA: begin
                        if (i_rx_valid) begin
                            r_cmd_data <= {r_cmd_data[23:0], i_rx_data};
                            r_idx      <= r_idx + 2'd1;
`ifdef RX_CHECKSUM_EN
                            r_xor      <= r_xor ^ i_rx_data;
                            if (r_idx == 2'd3) begin
                                r_state <= GET_CHK;
                            end
`else
                            if (r_idx == 2'd3) begin
                                r_state     <= HOLD;
                                r_cmd_valid <= 1'b1;
                            end
`endif
                        end
                    end

`ifdef RX_CHECKSUM_EN
                    GET_CHK: begin
                        if (i_rx_valid) begin
                            if (i_rx_data == r_xor) begin
                                r_state     <= HOLD;
                                r_cmd_valid <= 1'b1;
                            end else begin
                                r_state   <= HUNT;
                                r_busy    <= 1'b0;
                                r_err_chk <= 1'b1;
                            end
                        end
                    end
`endif

                    HOLD: begin
                        if (i_cmd_ready) begin
                            // On the handshake cycle, the incoming byte is
                            // treated as a HUNT byte, so back-to-back frames
                            // lose nothing.
                            r_cmd_valid <= 1'b0;
                            if (w_sync_seen) begin
                                r_state <= GET_OP;
                                r_idx   <= '0;
`ifdef RX_CHECKSUM_EN
                                r_xor   <= '0;
`endif
                            end else begin
                                r_state <= HUNT;
                                r_busy  <= 1'b0;
                            end
                        end else if (i_rx_valid) begin
                            r_err_overrun <= 1'b1;
                        end
                    end

                    default: begin
                        r_state     <= HUNT;
                        r_busy      <= 1'b0;
                        r_cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cmd_opcode  = r_cmd_opcode;
    assign o_cmd_addr    = r_cmd_addr;
    assign o_cmd_data    = r_cmd_data;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_busy        = r_busy;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
`ifdef RX_CHECKSUM_EN
    assign o_err_chk     = r_err_chk;
`else
    assign o_err_chk     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser.
// The stimulus pushes expected events (commands, error pulses) into a queue.
// A negedge monitor pops an entry and compares it whenever the DUT presents
// a command or an error pulse.
// The frame layout follows RX_CHECKSUM_EN, matching whichever RTL build is compiled.

module tb_uart_cmd_parser;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_cmd_opcode;
    logic [7:0]  o_cmd_addr;
    logic [31:0] o_cmd_data;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic        o_busy;
    logic        o_err_chk;
    logic        o_err_timeout;
    logic        o_err_overrun;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_cmd_opcode  (o_cmd_opcode),
        .o_cmd_addr    (o_cmd_addr),
        .o_cmd_data    (o_cmd_data),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_busy        (o_busy),
        .o_err_chk     (o_err_chk),
        .o_err_timeout (o_err_timeout),
        .o_err_overrun (o_err_overrun)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_CMD = 0, EV_CHK = 1, EV_TMO = 2, EV_OVR = 3} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        int          delay;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc        = 0;
    int  strobe_cyc = 0;

    // Cycle counter; records the cycle in which each byte strobe is sampled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_rx_valid) strobe_cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{EV_CMD, 8'h0, 8'h0, 32'h0, 0};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event actual=kind%0d required=none", int'(k));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(e.kind), 32'(k));
            ok = (e.kind == k);
        end
    endtask

    // Monitor: compares each presented command or error pulse against the queue.
    initial begin : monitor
        ev_t e;
        ev_t held;
        bit  ok;
        bit  held_ok  = 1'b0;
        bit  pv       = 1'b0;
        bit  pchk     = 1'b0;
        bit  ptmo     = 1'b0;
        bit  povr     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pchk = 1'b0; ptmo = 1'b0; povr = 1'b0; held_ok = 1'b0;
            end else begin
                if (o_cmd_valid && !pv) begin
                    take(EV_CMD, e, ok);
                    if (ok) begin
                        check("cmd_opcode", 32'(o_cmd_opcode), 32'(e.op));
                        check("cmd_addr",   32'(o_cmd_addr),   32'(e.addr));
                        check("cmd_data",   o_cmd_data,        e.data);
                    end
                    held    = e;
                    held_ok = ok;
                end else if (o_cmd_valid && held_ok) begin
                    check("hold_stable", {o_cmd_opcode, o_cmd_addr, o_cmd_data[15:0]},
                          {held.op, held.addr, held.data[15:0]});
                end
                if (o_err_chk) begin
                    if (pchk) check("err_chk_width", 32'd2, 32'd1);
                    else take(EV_CHK, e, ok);
                end
                if (o_err_timeout) begin
                    if (ptmo) check("err_timeout_width", 32'd2, 32'd1);
                    else begin
                        take(EV_TMO, e, ok);
                        if (ok) check("timeout_delay", 32'(cyc - strobe_cyc), 32'(e.delay));
                    end
                end
                if (o_err_overrun) begin
                    if (povr) check("err_overrun_width", 32'd2, 32'd1);
                    else take(EV_OVR, e, ok);
                end
                pv = o_cmd_valid; pchk = o_err_chk; ptmo = o_err_timeout; povr = o_err_overrun;
            end
        end
    end

    task automatic push_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back('{EV_CMD, op, addr, data, 0});
    endtask

    task automatic push_err(input ev_kind_t k, input int delay);
        exp_q.push_back('{k, 8'h0, 8'h0, 32'h0, delay});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                              input logic [31:0] data, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(addr);
        send_byte(data[31:24]);
        send_byte(data[23:16]);
        send_byte(data[15:8]);
        send_byte(data[7:0]);
`ifdef RX_CHECKSUM_EN
        send_byte(chk);
`else
        if (chk === 8'hxx) i_rx_data = 8'h00;
`endif
    endtask

    // Waits (bounded) for a held command, then accepts it with a one-cycle ready.
    task automatic accept(input string name);
        int t = 0;
        while (!o_cmd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid_latency"}, 32'(t), 32'd0);
        i_cmd_ready = 1'b1;
        @(negedge clk);
        i_cmd_ready = 1'b0;
        check({name, "_valid_after_ack"}, 32'(o_cmd_valid), 32'd0);
        check({name, "_busy_after_ack"},  32'(o_busy),      32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst         = 1'b1;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        i_cmd_ready = 1'b0;
        idle(3);
        check("rst_outputs", {o_cmd_valid, o_busy, o_err_chk, o_err_timeout, o_err_overrun}, 32'd0);
        check("rst_cmd", {o_cmd_opcode, o_cmd_addr, o_cmd_data[15:0]}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Valid frame, held while ready is low.
        push_cmd(8'h01, 8'h10, 32'hDEADBEEF);
        send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'h33);
        check("frame1_valid", 32'(o_cmd_valid), 32'd1);
        check("frame1_busy",  32'(o_busy),      32'd1);
        idle(4);
        check("frame1_still_held", 32'(o_cmd_valid), 32'd1);
        accept("frame1");

`ifdef RX_CHECKSUM_EN
        // Bad checksum, then a good frame.
        push_err(EV_CHK, 0);
        send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'h34);
        idle(2);
        check("badchk_valid", 32'(o_cmd_valid), 32'd0);
        check("badchk_busy",  32'(o_busy),      32'd0);
        push_cmd(8'h01, 8'h10, 32'hDEADBEEF);
        send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'h33);
        accept("after_badchk");
`endif

        // Leading noise, including 0xFF, is ignored silently.
        push_cmd(8'h02, 8'h20, 32'h00000001);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h02, 8'h20, 32'h00000001, 8'h23);
        accept("noise");

        // Inter-byte timeout: the pulse arrives exactly TMO clocks after the last strobe.
        push_err(EV_TMO, TMO);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        idle(60);
        check("tmo_busy",  32'(o_busy),      32'd0);
        check("tmo_valid", 32'(o_cmd_valid), 32'd0);
        push_cmd(8'h01, 8'h10, 32'hDEADBEEF);
        send_frame(8'h01, 8'h10, 32'hDEADBEEF, 8'h33);
        accept("after_tmo");

        // A byte landing in the expiry cycle wins; no timeout occurs.
        push_cmd(8'h01, 8'h10, 32'hDEADBEEF);
        send_byte(8'hA5);
        idle(TMO - 1);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef RX_CHECKSUM_EN
        send_byte(8'h33);
`endif
        accept("expiry_edge");

        // Overrun while holding, then a handshake coinciding with a sync byte.
        push_cmd(8'h03, 8'h40, 32'h12345678);
        send_frame(8'h03, 8'h40, 32'h12345678, 8'h4B);
        push_err(EV_OVR, 0);
        send_byte(8'h55);
        idle(1);
        check("ovr_still_valid", 32'(o_cmd_valid), 32'd1);
        check("ovr_cmd_data",    o_cmd_data,       32'h12345678);
        i_rx_data   = 8'hA5;
        i_rx_valid  = 1'b1;
        i_cmd_ready = 1'b1;
        @(negedge clk);
        i_rx_valid  = 1'b0;
        i_cmd_ready = 1'b0;
        check("sync_ack_valid",   32'(o_cmd_valid),   32'd0);
        check("sync_ack_busy",    32'(o_busy),        32'd1);
        check("sync_ack_overrun", 32'(o_err_overrun), 32'd0);
        push_cmd(8'h04, 8'h50, 32'hCAFEF00D);
        send_byte(8'h04);
        send_byte(8'h50);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
`ifdef RX_CHECKSUM_EN
        send_byte(8'h9D);
`endif
        accept("after_sync_ack");

        // Reset mid-frame discards the partial frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", {o_cmd_valid, o_busy, o_err_chk, o_err_timeout, o_err_overrun}, 32'd0);
        check("midrst_opcode",  32'(o_cmd_opcode), 32'd0);
        check("midrst_data",    o_cmd_data,        32'd0);
        send_byte(8'h10);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h33);
        idle(5);
        check("midrst_no_cmd", 32'(o_cmd_valid), 32'd0);
        check("midrst_idle",   32'(o_busy),      32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
